// File: rtl/multicore.sv
// multicore: NUM_CORES RV64I-subset cores with private instruction memories and a
// round-robin arbitrated, byte-addressed shared data memory (one access per cycle).
module multicore #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_SIZE = 1024,
  parameter int NUM_CORES = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic [NUM_CORES-1:0] core_active,
  output logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] pc_out,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] alu_result_out
);
  localparam int IWORDS = MEM_SIZE / 4;
  localparam int IW = $clog2(IWORDS);
  localparam int MW = $clog2(MEM_SIZE);
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  logic [31:0] instruction_mem [NUM_CORES][IWORDS];
  logic [7:0] data_mem [MEM_SIZE];
  logic [NUM_CORES-1:0] mem_request, mem_write, mem_dw;
  logic [ADDR_WIDTH-1:0] mem_addr [NUM_CORES];
  logic [DATA_WIDTH-1:0] st_data [NUM_CORES];
  logic [CW-1:0] rr, gidx;
  logic any_gnt;
  logic [63:0] ld_raw;
  // first active requester at or after the rotating pointer wins
  always_comb begin
    logic [CW-1:0] j;
    j = '0;
    any_gnt = 1'b0;
    gidx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = rr + CW'(k);
      if (!any_gnt && mem_request[j] && core_active[j]) begin
        any_gnt = 1'b1;
        gidx = j;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr <= '0;
    else if (any_gnt) rr <= gidx + CW'(1);
  always_comb begin
    ld_raw = '0;
    for (int k = 0; k < 8; k++) ld_raw[8*k +: 8] = data_mem[MW'(mem_addr[gidx] + ADDR_WIDTH'(k))];
  end
  always_ff @(posedge clk)
    if (any_gnt && mem_write[gidx])
      for (int k = 0; k < 8; k++)
        if (k < 4 || mem_dw[gidx]) data_mem[MW'(mem_addr[gidx] + ADDR_WIDTH'(k))] <= st_data[gidx][8*k +: 8];
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic [ADDR_WIDTH-1:0] pc, nxt;
    logic [DATA_WIDTH-1:0] rf [32];
    logic [DATA_WIDTH-1:0] cyc, ret, alu, a, b, ii, is, ib, ij, csr, res, ldv;
    logic [31:0] ins;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic act, upd, wb, ld, st, take, run;
    assign ins = instruction_mem[c][pc[IW+1:2]];
    assign {f7, f3, rd, op} = {ins[31:25], ins[14:12], ins[11:7], ins[6:0]};
    assign a = rf[ins[19:15]];
    assign b = rf[ins[24:20]];
    assign ii = DATA_WIDTH'($signed(ins[31:20]));
    assign is = DATA_WIDTH'($signed({ins[31:25], ins[11:7]}));
    assign ib = DATA_WIDTH'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    assign ij = DATA_WIDTH'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    assign csr = ins[31:20] == 12'hC00 || ins[31:20] == 12'hC01 ? cyc : ins[31:20] == 12'hC02 ? ret : '0;
    assign ldv = mem_dw[c] ? DATA_WIDTH'(ld_raw) : DATA_WIDTH'($signed(ld_raw[31:0]));
    // a requesting core only advances in the cycle it holds the grant
    assign run = act && !(mem_request[c] && !(any_gnt && gidx == CW'(c)));
    assign mem_request[c] = ld || st;
    assign mem_write[c] = st;
    assign mem_dw[c] = f3[0];
    assign mem_addr[c] = ADDR_WIDTH'(ld ? a + ii : a + is);
    assign st_data[c] = b;
    assign core_active[c] = act;
    assign pc_out[c] = pc;
    assign alu_result_out[c] = alu;
    always_comb begin
      res = '0;
      upd = 1'b0;
      wb = 1'b0;
      ld = 1'b0;
      st = 1'b0;
      take = 1'b0;
      nxt = pc + ADDR_WIDTH'(4);
      case (op)
        7'b0010011: begin
          upd = f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7;
          wb = upd;
          res = f3 == 3'd0 ? a + ii : f3 == 3'd4 ? a ^ ii : f3 == 3'd6 ? a | ii : a & ii;
        end
        7'b0110011: begin
          upd = (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7)) || (f7 == 7'h20 && f3 == 3'd0);
          wb = upd;
          res = f3 == 3'd4 ? a ^ b : f3 == 3'd6 ? a | b : f3 == 3'd7 ? a & b : f7[5] ? a - b : a + b;
        end
        7'b0000011: begin
          ld = f3 == 3'd2 || f3 == 3'd3;
          upd = ld;
          wb = ld;
          res = a + ii;
        end
        7'b0100011: begin
          st = f3 == 3'd2 || f3 == 3'd3;
          upd = st;
          res = a + is;
        end
        7'b1100011: begin
          upd = f3 != 3'd2 && f3 != 3'd3;
          res = a - b;
          take = f3 == 3'd0 ? a == b : f3 == 3'd1 ? a != b : f3 == 3'd4 ? $signed(a) < $signed(b) :
                 f3 == 3'd5 ? $signed(a) >= $signed(b) : f3 == 3'd6 ? a < b : a >= b;
          if (upd && take) nxt = pc + ADDR_WIDTH'(ib);
        end
        7'b1101111: begin
          upd = 1'b1;
          wb = 1'b1;
          res = DATA_WIDTH'(pc + ADDR_WIDTH'(4));
          nxt = pc + ADDR_WIDTH'(ij);
        end
        7'b1110011: begin
          upd = f3 == 3'd2;
          wb = upd;
          res = csr;
        end
        default: ;
      endcase
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        pc <= '0;
        act <= 1'b0;
        cyc <= '0;
        ret <= '0;
        alu <= '0;
        for (int r = 0; r < 32; r++) rf[r] <= '0;
      end else begin
        act <= 1'b1;
        if (act) cyc <= cyc + 1'b1;
        if (run) begin
          pc <= nxt;
          ret <= ret + 1'b1;
          if (upd) alu <= res;
          if (wb && rd != 5'd0) rf[rd] <= ld ? ldv : res;
        end
      end
  end
endmodule

// File: tb/tb_multicore.sv
// tb_multicore: lockstep comparison of multicore against an instruction-level
// interpreter of the four cores, shared memory and round-robin arbitration.
module tb_multicore;
  localparam int N = 4;
  localparam int MS = 1024;
  localparam int IWN = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] core_active;
  logic [N-1:0][63:0] pc_out, alu_result_out;
  multicore dut (.clk(clk), .rst_n(rst_n), .core_active(core_active), .pc_out(pc_out), .alu_result_out(alu_result_out));
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] prog [N][IWN];
  logic [7:0] m_mem [MS];
  logic [63:0] m_pc [N], m_cyc [N], m_ret [N], m_alu [N];
  logic [63:0] m_x [N][32];
  logic m_act;
  int m_rr;
  logic [63:0] h_pc [N][64], h_alu [N][64], h_addr1 [64];
  logic h_wr1 [64];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [11:0] im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [12:0] im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [20:0] im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] rnd_ins();
    int rd = $urandom_range(7);
    int r1 = $urandom_range(7);
    int r2 = $urandom_range(7);
    int f = $urandom_range(4);
    case ($urandom_range(9))
      0, 1: return enc_i($urandom_range(4095), r1, f == 0 ? 0 : f == 1 ? 4 : f == 2 ? 6 : 7, rd, 7'h13);
      2: return enc_r(f == 1 ? 32 : 0, r2, r1, f < 2 ? 0 : f == 2 ? 4 : f == 3 ? 6 : 7, rd);
      3: return enc_i($urandom_range(4095), r1, $urandom_range(2, 3), rd, 7'h03);
      4: return enc_s($urandom_range(4095), r2, r1, $urandom_range(2, 3));
      5: return enc_b(int'(4 * $urandom_range(12)) - 16, r2, r1, $urandom_range(7));
      6: return enc_j(int'(4 * $urandom_range(1, 16)), rd);
      7: return enc_i(f > 2 ? 'h300 : 'hC00 + f, r1, 2, rd, 7'h73);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [63:0] sx(logic [63:0] v, int w);
    logic [63:0] r = v;
    for (int k = w; k < 64; k++) r[k] = v[w-1];
    return r;
  endfunction
  function automatic logic [31:0] cur(int c);
    return prog[c][m_pc[c][9:2]];
  endfunction
  function automatic logic mem_op(logic [31:0] i);
    return (i[6:0] == 7'h03 || i[6:0] == 7'h23) && i[14:13] == 2'b01;
  endfunction
  function automatic logic [63:0] m_ea(int c);
    logic [31:0] i = cur(c);
    return m_x[c][i[19:15]] + sx(i[6:0] == 7'h03 ? 64'(i[31:20]) : 64'({i[31:25], i[11:7]}), 12);
  endfunction
  function automatic logic [63:0] rd_mem(logic [63:0] ea, int n);
    logic [63:0] r = '0;
    logic [9:0] ix;
    for (int k = 0; k < n; k++) begin
      ix = ea[9:0] + 10'(k);
      r[8*k +: 8] = m_mem[ix];
    end
    return r;
  endfunction
  task automatic wr_mem(logic [63:0] ea, logic [63:0] d, int n);
    logic [9:0] ix;
    for (int k = 0; k < n; k++) begin
      ix = ea[9:0] + 10'(k);
      m_mem[ix] = d[8*k +: 8];
    end
  endtask

  task automatic exec(int c);
    logic [31:0] i;
    logic [2:0] f3;
    logic [63:0] a, b, v, ea, npc;
    logic up, wr, ld, tk;
    i = cur(c);
    f3 = i[14:12];
    a = m_x[c][i[19:15]];
    b = m_x[c][i[24:20]];
    {up, wr, ld, tk} = '0;
    v = '0;
    ea = '0;
    npc = m_pc[c] + 4;
    case (i[6:0])
      7'h13: begin
        ea = sx(64'(i[31:20]), 12);
        up = 1'b1;
        case (f3)
          3'd0: v = a + ea;
          3'd4: v = a ^ ea;
          3'd6: v = a | ea;
          3'd7: v = a & ea;
          default: up = 1'b0;
        endcase
        wr = up;
      end
      7'h33: begin
        up = 1'b1;
        case ({i[31:25], f3})
          {7'h00, 3'd0}: v = a + b;
          {7'h20, 3'd0}: v = a - b;
          {7'h00, 3'd4}: v = a ^ b;
          {7'h00, 3'd6}: v = a | b;
          {7'h00, 3'd7}: v = a & b;
          default: up = 1'b0;
        endcase
        wr = up;
      end
      7'h03: if (mem_op(i)) begin
        v = m_ea(c);
        ea = rd_mem(v, f3 == 3'd3 ? 8 : 4);
        if (f3 == 3'd2) ea = sx(ea, 32);
        {up, wr, ld} = 3'b111;
      end
      7'h23: if (mem_op(i)) begin
        v = m_ea(c);
        wr_mem(v, b, f3 == 3'd3 ? 8 : 4);
        up = 1'b1;
      end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        up = 1'b1;
        v = a - b;
        case (f3)
          3'd0: tk = a == b;
          3'd1: tk = a != b;
          3'd4: tk = $signed(a) < $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a < b;
          default: tk = a >= b;
        endcase
        if (tk) npc = m_pc[c] + sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
      end
      7'h6f: begin
        {up, wr} = 2'b11;
        v = m_pc[c] + 4;
        npc = m_pc[c] + sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
      end
      7'h73: if (f3 == 3'd2) begin
        {up, wr} = 2'b11;
        v = (i[31:20] == 12'hC00 || i[31:20] == 12'hC01) ? m_cyc[c] : i[31:20] == 12'hC02 ? m_ret[c] : 64'd0;
      end
      default: ;
    endcase
    if (up) m_alu[c] = v;
    if (wr && i[11:7] != 5'd0) m_x[c][i[11:7]] = ld ? ea : v;
    m_pc[c] = npc;
    m_ret[c]++;
  endtask

  task automatic model_step();
    int win = -1;
    if (!m_act) begin
      m_act = 1'b1;
      return;
    end
    for (int k = 0; k < N; k++)
      if (win < 0 && mem_op(cur((m_rr + k) % N))) win = (m_rr + k) % N;
    for (int c = 0; c < N; c++) begin
      if (!mem_op(cur(c)) || c == win) exec(c);
      m_cyc[c]++;
    end
    if (win >= 0) m_rr = (win + 1) % N;
  endtask

  task automatic m_reset();
    m_act = 1'b0;
    m_rr = 0;
    for (int c = 0; c < N; c++) begin
      {m_pc[c], m_cyc[c], m_ret[c], m_alu[c]} = '0;
      for (int r = 0; r < 32; r++) m_x[c][r] = '0;
    end
  endtask

  task automatic check_all(int s);
    logic [31:0] i;
    for (int c = 0; c < N; c++) begin
      i = cur(c);
      check($sformatf("act%0d s%0d", c, s), 64'(core_active[c]), 64'(m_act));
      check($sformatf("pc%0d s%0d", c, s), pc_out[c], m_pc[c]);
      check($sformatf("alu%0d s%0d", c, s), alu_result_out[c], m_alu[c]);
      check($sformatf("req%0d s%0d", c, s), 64'(dut.mem_request[c]), 64'(mem_op(i)));
      check($sformatf("we%0d s%0d", c, s), 64'(dut.mem_write[c]), 64'(mem_op(i) && i[5]));
      if (mem_op(i)) check($sformatf("addr%0d s%0d", c, s), dut.mem_addr[c], m_ea(c));
    end
  endtask

  task automatic run(int n);
    for (int s = 0; s < n; s++) begin
      check_all(s);
      if (s < 64) begin
        for (int c = 0; c < N; c++) begin
          h_pc[c][s] = pc_out[c];
          h_alu[c][s] = alu_result_out[c];
        end
        h_addr1[s] = dut.mem_addr[1];
        h_wr1[s] = dut.mem_write[1];
      end
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic load_and_reset();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < IWN; j++) dut.instruction_mem[c][j] = prog[c][j];
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    for (int j = 0; j < MS; j++) begin
      dut.data_mem[j] = 8'h00;
      m_mem[j] = 8'h00;
    end
    for (int c = 0; c < N; c++)
      for (int j = 0; j < IWN; j++) prog[c][j] = '0;
    prog[0][0] = enc_i(5, 0, 0, 1, 7'h13);
    prog[0][1] = enc_i(10, 0, 0, 2, 7'h13);
    prog[0][2] = enc_r(0, 2, 1, 0, 3);
    prog[0][3] = enc_r(32, 1, 2, 0, 4);
    prog[1][0] = enc_i(0, 0, 2, 3, 7'h03);
    prog[1][1] = enc_s(0, 1, 0, 2);
    prog[1][2] = enc_s(4, 1, 0, 2);
    prog[1][3] = enc_s(8, 1, 0, 2);
    prog[2][0] = enc_b(0, 2, 1, 0);
    prog[3][0] = enc_i('hC00, 0, 2, 5, 7'h73);
    prog[3][1] = enc_i('hC02, 0, 2, 6, 7'h73);
    prog[3][2] = enc_i(1, 0, 0, 7, 7'h13);
    prog[3][3] = enc_i('hC00, 0, 2, 8, 7'h73);
    load_and_reset();
    run(40);
    for (int s = 1; s <= 5; s++) check($sformatf("dir pc0 s%0d", s), h_pc[0][s], 64'(4 * (s - 1)));
    check("dir alu0 addi5", h_alu[0][2], 64'd5);
    check("dir alu0 addi10", h_alu[0][3], 64'hA);
    check("dir alu0 add", h_alu[0][4], 64'hF);
    check("dir alu0 sub", h_alu[0][5], 64'd5);
    for (int s = 1; s <= 4; s++) begin
      check($sformatf("dir addr1 s%0d", s), h_addr1[s], 64'(s < 2 ? 0 : 4 * (s - 2)));
      check($sformatf("dir we1 s%0d", s), 64'(h_wr1[s]), 64'(s > 1));
    end
    check("dir pc2 stuck", h_pc[2][39], 64'd0);
    check("dir alu2 zero", h_alu[2][39], 64'd0);
    check("dir csr cycle0", h_alu[3][2], 64'd0);
    check("dir csr instret", h_alu[3][3], 64'd1);
    check("dir csr cycle3", h_alu[3][6], 64'd3);
    for (int c = 0; c < N; c++) begin
      for (int j = 0; j < IWN; j++) prog[c][j] = '0;
      prog[c][0] = enc_i(0, 0, 2, 1, 7'h03);
      prog[c][1] = enc_i(8, 0, 2, 2, 7'h03);
    end
    load_and_reset();
    run(20);
    for (int c = 0; c < N; c++) begin
      check($sformatf("rr hold%0d", c), h_pc[c][1 + c], 64'd0);
      check($sformatf("rr grant%0d", c), h_pc[c][2 + c], 64'd4);
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < N; c++)
        for (int j = 0; j < IWN; j++) prog[c][j] = rnd_ins();
      load_and_reset();
      run(150);
    end
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < N; c++) begin
      check($sformatf("arst pc%0d", c), pc_out[c], 64'd0);
      check($sformatf("arst alu%0d", c), alu_result_out[c], 64'd0);
      check($sformatf("arst act%0d", c), 64'(core_active[c]), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int k = 0; k < 16; k++) begin
      int c = k % N;
      int j = $urandom_range(IWN - 1);
      check($sformatf("imem %0d/%0d", c, j), 64'(dut.instruction_mem[c][j]), 64'(prog[c][j]));
    end
    run(120);
    for (int j = 0; j < MS; j += 8) begin
      logic [63:0] d = '0;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = dut.data_mem[j + k];
      check($sformatf("dmem %0d", j), d, rd_mem(64'(j), 8));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
